fake_netlist_stim_capture: RTL
==============================

# fake_netlist_stim_capture

Sequential stimulus/response harness for the single-output combinational fake netlists. It drives the netlist's primary inputs from an LFSR pattern source and compacts the netlist's output into a MISR signature, one vector per step, with a start/done handshake. It instantiates beside a fake netlist instance and lets a sequential test or on-chip self-check compare the netlist's final signature against a golden value.

## Interface
- N_IN, 3: number of netlist inputs driven; 1..LFSR_W.
- LFSR_W, 8: pattern LFSR width; fixed Galois polynomial 0xB8.
- MISR_W, 16: signature width; fixed polynomial 0x1021.
- NUM_VECTORS, 256: vectors applied per run; 1..2^16-1.
- SETTLE, 1: cycles each vector is held before capture; ≥1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begins a run when sampled high in IDLE or DONE.
- abort  in  1  synchronous stop; returns to IDLE.
- seed  in  LFSR_W  LFSR start value, sampled on accepted start; 0 is replaced by 1.
- dut_in  out  N_IN  registered drive to netlist inputs (= lfsr[N_IN-1:0]).
- dut_out  in  1  netlist output.
- busy  out  1  high in APPLY/CAPTURE.
- done  out  1  level, high in DONE.
- signature  out  MISR_W  MISR contents.
- vec_count  out  16  vectors captured this run.

## Operation
- States: IDLE, APPLY, CAPTURE, DONE.
- IDLE/DONE + start: load lfsr=seed (or 1), signature=0, vec_count=0, settle counter=0, go APPLY.
- APPLY: hold dut_in; after SETTLE cycles in APPLY go CAPTURE.
- CAPTURE (one cycle): signature ← {signature[MISR_W-2:0],0} ^ (signature[MISR_W-1] ? 0x1021 : 0) ^ dut_out; vec_count+1; lfsr ← (lfsr>>1) ^ (lfsr[0] ? 0xB8 : 0). If new vec_count == NUM_VECTORS go DONE, else APPLY.
- dut_in always equals lfsr[N_IN-1:0] (registered alongside lfsr).
- DONE: signature, vec_count, dut_in frozen until start or reset.
- start while busy: ignored. abort in any state: IDLE next cycle, signature/vec_count retained, done low. abort and start same cycle: abort wins.
- All arithmetic modulo its width; vec_count never exceeds NUM_VECTORS.

## Timing
- Reset values: state IDLE, dut_in 0, lfsr 0, signature 0, vec_count 0, busy 0, done 0.
- Reset mid-run: immediate return to reset values; no partial result retained.
- Start accepted at edge k: busy=1 and dut_in valid from k+1.
- Per vector: SETTLE cycles APPLY + 1 cycle CAPTURE; dut_out sampled at the CAPTURE edge, i.e. after SETTLE+1 cycles of stable dut_in (netlist path must fit in SETTLE cycles).
- done rises exactly NUM_VECTORS*(SETTLE+1) cycles after the start-accept edge; busy falls the same cycle.

## Structure
- Package fnl_harness_pkg: state enum, LFSR_POLY (0xB8), MISR_POLY (0x1021), MISR update function.
- One sub-module: fnl_misr (clear, enable, serial in, signature out), reusable by other netlist harnesses.
- FSM, settle counter, LFSR and vector counter stay in the top.

## Test plan
- Reset then idle: all outputs 0; start with seed=0x01, NUM_VECTORS=4, SETTLE=1 -> dut_in sequence 3'b001, 3'b000, 3'b100, 3'b110, each held 2 cycles.
- dut_out tied 1, NUM_VECTORS=4 -> signature 0x0001, 0x0003, 0x0007, 0x000F after successive captures; done at cycle 8 after start, vec_count=4.
- dut_out tied 0, any run -> signature stays 0x0000; seed=0 behaves identically to seed=1.
- Abort in third vector -> IDLE next cycle, done 0, vec_count=2 retained; start in DONE restarts with signature cleared.
- Assert rst_n low mid-CAPTURE -> all outputs 0 asynchronously; start while busy ignored (done timing unchanged).
- Connect a fake netlist instance, NUM_VECTORS=256 -> signature matches golden model computed from the same LFSR/MISR equations.

Source files
------------

// File: rtl/fnl_harness_pkg.sv
// Shared types, polynomials and the MISR step function for fake-netlist stimulus/capture harnesses.
package fnl_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [31:0] LFSR_POLY = 32'h0000_00B8;
    localparam logic [31:0] MISR_POLY = 32'h0000_1021;

    // One MISR shift of a w-bit signature held in the low bits of a 32-bit word.
    function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                              input logic        din,
                                              input int unsigned w);
        logic [31:0] mask_v;
        logic [31:0] poly_v;
        logic [31:0] res_v;
        mask_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'h0000_0001 << w) - 32'h0000_0001);
        poly_v = sig[w-1] ? MISR_POLY : 32'h0000_0000;
        res_v  = ((sig << 1) ^ poly_v) & mask_v;
        res_v[0] = res_v[0] ^ din;
        return res_v;
    endfunction

endpackage

// File: rtl/fnl_misr.sv
// Serial-input MISR signature compactor with synchronous clear and capture enable.
module fnl_misr
    import fnl_harness_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic         serial_in,
    output logic [W-1:0] signature
);

    logic [W-1:0] sig_r;
    logic [31:0]  sig_ext_s;
    logic [31:0]  next_ext_s;

    // Widen the signature to the helper's word size and compute the next value.
    always_comb begin
        sig_ext_s        = 32'h0000_0000;
        sig_ext_s[W-1:0] = sig_r;
        next_ext_s       = misr_step(sig_ext_s, serial_in, W);
    end

    // Signature register: clear has priority over a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= {W{1'b0}};
        end else if (clear) begin
            sig_r <= {W{1'b0}};
        end else if (enable) begin
            sig_r <= next_ext_s[W-1:0];
        end else begin
            sig_r <= sig_r;
        end
    end

    assign signature = sig_r;

endmodule

// File: rtl/fake_netlist_stim_capture.sv
// LFSR-driven stimulus and MISR capture harness for a single-output combinational fake netlist.
module fake_netlist_stim_capture
    import fnl_harness_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int LFSR_W      = 8,
    parameter int MISR_W      = 16,
    parameter int NUM_VECTORS = 256,
    parameter int SETTLE      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [LFSR_W-1:0] seed,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature,
    output logic [15:0]       vec_count
);

    localparam logic [LFSR_W-1:0] LFSR_POLY_L = LFSR_POLY[LFSR_W-1:0];
    localparam logic [LFSR_W-1:0] LFSR_ONE    = LFSR_W'(1);
    localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [15:0]       NUM_VEC_L   = 16'(NUM_VECTORS);

    state_e            state_r;
    state_e            next_state_s;
    logic              load_s;
    logic              capture_s;
    logic [15:0]       settle_cnt_r;
    logic [LFSR_W-1:0] lfsr_r;
    logic [LFSR_W-1:0] lfsr_next_s;
    logic [LFSR_W-1:0] seed_eff_s;
    logic [15:0]       vec_count_r;

    // Next-state and strobe decode; abort overrides everything including start.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_s       = 1'b1;
                    next_state_s = ST_APPLY;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_APPLY: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    next_state_s = ST_CAPTURE;
                end else begin
                    next_state_s = ST_APPLY;
                end
            end
            ST_CAPTURE: begin
                capture_s = 1'b1;
                if ((vec_count_r + 16'd1) == NUM_VEC_L) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_APPLY;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        if (abort) begin
            next_state_s = ST_IDLE;
            load_s       = 1'b0;
            capture_s    = 1'b0;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // LFSR advance and zero-seed substitution (an all-zero Galois LFSR would lock up).
    always_comb begin
        lfsr_next_s = (lfsr_r >> 1) ^ (lfsr_r[0] ? LFSR_POLY_L : {LFSR_W{1'b0}});
        seed_eff_s  = (seed == {LFSR_W{1'b0}}) ? LFSR_ONE : seed;
    end

    // State register plus registered status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy    <= (next_state_s == ST_APPLY) || (next_state_s == ST_CAPTURE);
            done    <= (next_state_s == ST_DONE);
        end
    end

    // Settle counter: counts cycles spent in APPLY for the current vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= 16'd0;
        end else if ((state_r == ST_APPLY) && (next_state_s == ST_APPLY)) begin
            settle_cnt_r <= settle_cnt_r + 16'd1;
        end else begin
            settle_cnt_r <= 16'd0;
        end
    end

    // Pattern LFSR, netlist drive and vector counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r      <= {LFSR_W{1'b0}};
            dut_in      <= {N_IN{1'b0}};
            vec_count_r <= 16'd0;
        end else if (load_s) begin
            lfsr_r      <= seed_eff_s;
            dut_in      <= seed_eff_s[N_IN-1:0];
            vec_count_r <= 16'd0;
        end else if (capture_s) begin
            lfsr_r      <= lfsr_next_s;
            dut_in      <= lfsr_next_s[N_IN-1:0];
            vec_count_r <= vec_count_r + 16'd1;
        end else begin
            lfsr_r      <= lfsr_r;
            dut_in      <= dut_in;
            vec_count_r <= vec_count_r;
        end
    end

    assign vec_count = vec_count_r;

    fnl_misr #(
        .W(MISR_W)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (load_s),
        .enable    (capture_s),
        .serial_in (dut_out),
        .signature (signature)
    );

endmodule
